// File: rtl/fft16_pkg.sv
// Shared constants and FSM state encoding for the FFT16 core scheduler.
package fft16_pkg;
    localparam int FRAME_W  = 512;
    localparam int CORE_LAT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/fft16_rr_arb.sv
// Two-requester arbiter for the FFT16 scheduler.
// FFT16_SCHED_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module fft16_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] adv,
    output logic [1:0] win
);
`ifdef FFT16_SCHED_RR_EN
    // ptr=0 favours requester 0; adv is one-hot on the requester whose result was accepted
    logic ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= 1'b0;
        else if (|adv)
            ptr <= adv[0];
    end

    always_comb begin
        win = req;
        if (req == 2'b11)
            win = ptr ? 2'b10 : 2'b01;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, reset, adv};

    always_comb begin
        win = 2'b00;
        if (req[0])
            win = 2'b01;
        else if (req[1])
            win = 2'b10;
    end
`endif
endmodule

// File: rtl/fft16_sched.sv
// Schedules frames from two requesters onto one shared FFT16 core.
// Arbitration policy is set by FFT16_SCHED_RR_EN (see fft16_rr_arb).
module fft16_sched #(
    parameter int FRAME_W  = fft16_pkg::FRAME_W,
    parameter int CORE_LAT = fft16_pkg::CORE_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [FRAME_W-1:0] frame_in0,
    input  logic [FRAME_W-1:0] frame_in1,
    output logic [1:0]         gnt,
    output logic               core_en,
    output logic [FRAME_W-1:0] core_bus_in,
    input  logic [FRAME_W-1:0] core_bus_out,
    output logic               res_valid,
    output logic               res_id,
    output logic [FRAME_W-1:0] res_data,
    input  logic               res_ready
);
    import fft16_pkg::*;

    if (CORE_LAT < 1 || CORE_LAT > 15) begin : g_lat_chk
        $error("CORE_LAT must be in 1..15");
    end

    localparam logic [3:0] LAST = 4'(CORE_LAT - 1);

    state_t             state, nxt;
    logic [FRAME_W-1:0] frame_reg;
    logic [3:0]         cnt;
    logic               job_id;
    logic [1:0]         win;
    logic [1:0]         adv;
    logic               accept;

    assign accept      = (state == HOLD) && res_ready;
    assign adv         = accept ? (res_id ? 2'b10 : 2'b01) : 2'b00;
    assign core_bus_in = frame_reg;

    fft16_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .adv   (adv),
        .win   (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            frame_reg <= '0;
            cnt       <= '0;
            job_id    <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (|req) begin
                    frame_reg <= win[1] ? frame_in1 : frame_in0;
                    job_id    <= win[1];
                    cnt       <= '0;
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        res_data <= core_bus_out;
                        res_id   <= job_id;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (|req) nxt = RUN;
            RUN:     if (cnt == LAST) nxt = HOLD;
            HOLD:    if (res_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // gnt is combinational in IDLE so it can never appear in RUN/HOLD or under reset
    always_comb begin
        gnt       = (reset && state == IDLE) ? win : 2'b00;
        core_en   = (state == RUN);
        res_valid = (state == HOLD);
    end
endmodule

// File: tb/tb_fft16_sched.sv
// Directed self-checking bench for fft16_sched (default CORE_LAT and CORE_LAT=1 instances).
module tb_fft16_sched;
    localparam int FW = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [FW-1:0] frame_in0 = '0, frame_in1 = '0;
    logic [1:0]    gnt;
    logic          core_en;
    logic [FW-1:0] core_bus_in, core_bus_out, res_data;
    logic          res_valid, res_id;
    logic          res_ready = 1'b0;

    logic [1:0]    l_req = 2'b00;
    logic [FW-1:0] l_f0 = '0, l_f1 = '0;
    logic [1:0]    l_gnt;
    logic          l_core_en;
    logic [FW-1:0] l_core_in, l_core_out, l_data;
    logic          l_valid, l_id;
    logic          l_ready = 1'b0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Stand-in FFT core: bitwise inversion of the input frame
    assign core_bus_out = ~core_bus_in;
    assign l_core_out   = ~l_core_in;

    fft16_sched #(.FRAME_W(FW), .CORE_LAT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .frame_in0(frame_in0), .frame_in1(frame_in1),
        .gnt(gnt), .core_en(core_en), .core_bus_in(core_bus_in), .core_bus_out(core_bus_out),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready)
    );

    fft16_sched #(.FRAME_W(FW), .CORE_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req(l_req), .frame_in0(l_f0), .frame_in1(l_f1),
        .gnt(l_gnt), .core_en(l_core_en), .core_bus_in(l_core_in), .core_bus_out(l_core_out),
        .res_valid(l_valid), .res_id(l_id), .res_data(l_data), .res_ready(l_ready)
    );

    logic [FW-1:0] ramp;
    logic [FW-1:0] pat_a;
    logic [FW-1:0] pat_b;
    logic [FW-1:0] pat_c;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req = 2'b00; res_ready = 1'b0; l_req = 2'b00; l_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL rst_gnt got %b want 00", gnt); end
        nvec++; if (core_en !== 1'b0) begin nerr++; $display("FAIL rst_core_en got %b want 0", core_en); end
        nvec++; if (res_valid !== 1'b0 || res_id !== 1'b0) begin nerr++; $display("FAIL rst_res got v=%b id=%b want 0 0", res_valid, res_id); end
        nvec++; if (res_data !== '0 || core_bus_in !== '0) begin nerr++; $display("FAIL rst_data got res_data/core_bus_in nonzero want 0"); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        int n;
        do_reset();
        frame_in0 = ramp; req = 2'b01; #1;
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL single_gnt got %b want 01", gnt); end
        @(negedge clk); req = 2'b00; #1;
        nvec++; if (core_en !== 1'b1 || gnt !== 2'b00) begin nerr++; $display("FAIL single_run got core_en=%b gnt=%b want 1 00", core_en, gnt); end
        nvec++; if (core_bus_in !== ramp) begin nerr++; $display("FAIL single_bus got %h want %h", core_bus_in, ramp); end
        n = 1;
        while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        nvec++; if (n != 5) begin nerr++; $display("FAIL single_lat got %0d want 5", n); end
        nvec++; if (res_id !== 1'b0 || core_en !== 1'b0) begin nerr++; $display("FAIL single_id got id=%b core_en=%b want 0 0", res_id, core_en); end
        nvec++; if (res_data !== ~ramp) begin nerr++; $display("FAIL single_data got %h want %h", res_data, ~ramp); end
        @(negedge clk); #1;
        nvec++; if (res_valid !== 1'b1) begin nerr++; $display("FAIL single_hold got %b want 1", res_valid); end
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0; #1;
        nvec++; if (res_valid !== 1'b0) begin nerr++; $display("FAIL single_accept got %b want 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [1:0] exp_g [4];
`ifdef FFT16_SCHED_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        do_reset();
        frame_in0 = pat_a; frame_in1 = pat_b; req = 2'b11; res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n = 0; #1;
            while (gnt === 2'b00 && n < 40) begin @(negedge clk); #1; n++; end
            nvec++; if (gnt !== exp_g[j]) begin nerr++; $display("FAIL tie_gnt%0d got %b want %b", j, gnt, exp_g[j]); end
            @(negedge clk);
        end
        req = 2'b00;
        repeat (8) @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        logic bad;
        do_reset();
        frame_in0 = pat_a; req = 2'b01; #1;
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL bp_gnt0 got %b want 01", gnt); end
        @(negedge clk); req = 2'b00; #1;
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        frame_in1 = pat_b; req = 2'b10;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (gnt !== 2'b00 || res_valid !== 1'b1 || res_data !== ~pat_a || res_id !== 1'b0) bad = 1'b1;
        end
        nvec++; if (bad) begin nerr++; $display("FAIL bp_stall got gnt=%b valid=%b id=%b want 00 1 0 with stable data", gnt, res_valid, res_id); end
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0; #1;
        nvec++; if (gnt !== 2'b10 || res_valid !== 1'b0) begin nerr++; $display("FAIL bp_gnt1 got gnt=%b valid=%b want 10 0", gnt, res_valid); end
        @(negedge clk); req = 2'b00; #1;
        nvec++; if (core_bus_in !== pat_b) begin nerr++; $display("FAIL bp_bus got %h want %h", core_bus_in, pat_b); end
        n = 0;
        while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        nvec++; if (res_id !== 1'b1 || res_data !== ~pat_b) begin nerr++; $display("FAIL bp_res1 got id=%b data=%h want 1 %h", res_id, res_data, ~pat_b); end
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic bad;
        do_reset();
        frame_in0 = pat_c; frame_in1 = pat_b; req = 2'b11; #1;
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL mid_gnt got %b want 01", gnt); end
        @(negedge clk); req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0; #1;
        nvec++; if (gnt !== 2'b00 || core_en !== 1'b0 || res_valid !== 1'b0 || res_id !== 1'b0) begin
            nerr++; $display("FAIL mid_outs got gnt=%b core_en=%b valid=%b id=%b want 00 0 0 0", gnt, core_en, res_valid, res_id);
        end
        nvec++; if (res_data !== '0 || core_bus_in !== '0) begin nerr++; $display("FAIL mid_data got res_data/core_bus_in nonzero want 0"); end
        @(negedge clk); reset = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (res_valid !== 1'b0 || gnt !== 2'b00 || core_en !== 1'b0) bad = 1'b1;
        end
        nvec++; if (bad) begin nerr++; $display("FAIL mid_quiet got activity after reset want none"); end
        req = 2'b11; #1;
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL mid_regnt got %b want 01", gnt); end
        @(negedge clk); req = 2'b00; res_ready = 1'b1;
        repeat (8) @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_lat1();
        do_reset();
        l_f1 = pat_c; l_req = 2'b10; #1;
        nvec++; if (l_gnt !== 2'b10) begin nerr++; $display("FAIL lat1_gnt got %b want 10", l_gnt); end
        @(negedge clk); l_req = 2'b00; #1;
        nvec++; if (l_core_en !== 1'b1 || l_valid !== 1'b0) begin nerr++; $display("FAIL lat1_run got core_en=%b valid=%b want 1 0", l_core_en, l_valid); end
        @(negedge clk); #1;
        nvec++; if (l_core_en !== 1'b0 || l_valid !== 1'b1) begin nerr++; $display("FAIL lat1_res got core_en=%b valid=%b want 0 1", l_core_en, l_valid); end
        nvec++; if (l_id !== 1'b1 || l_data !== ~pat_c) begin nerr++; $display("FAIL lat1_data got id=%b data=%h want 1 %h", l_id, l_data, ~pat_c); end
        l_ready = 1'b1;
        @(negedge clk); l_ready = 1'b0; #1;
        nvec++; if (l_valid !== 1'b0) begin nerr++; $display("FAIL lat1_accept got %b want 0", l_valid); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ramp[i*32 +: 32] = 32'(i);
        pat_a = {16{32'hA5A5_0F0F}};
        pat_b = {16{32'h1234_5678}};
        pat_c = {16{32'hDEAD_BEEF}};
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_lat1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
